// File: rtl/servo_pkg.sv
// servo_pkg: constants, decoder state type and the width-to-position helper
// shared by the servo PWM decoder sources.
package servo_pkg;

    localparam int POS_OFFSET = 165;
    localparam int CTR_W      = 20;
    localparam int TO_W       = 21;
    localparam int POS_MAX    = 255;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } dec_state_t;

    // Inverse of the generator mapping: subtract the offset and clamp to 0..255.
    // Comparing before subtracting gives the same result as a signed difference
    // followed by saturation, without needing a wider signed intermediate.
    function automatic logic [7:0] width_to_pos(input logic [CTR_W-1:0] coarse);
        logic [7:0] p;
        if (coarse < CTR_W'(POS_OFFSET)) begin
            p = 8'd0;
        end else if (coarse > CTR_W'(POS_OFFSET + POS_MAX)) begin
            p = 8'd255;
        end else begin
            p = 8'(coarse - CTR_W'(POS_OFFSET));
        end
        return p;
    endfunction

endpackage

// File: rtl/servo_in_sync.sv
// servo_in_sync: brings the asynchronous PWM pin into the clk domain and
// produces the level plus single-cycle rise/fall flags used by the decoder.
// Building with SERVO_DEC_GLITCH_EN adds a 3-sample majority filter after the
// synchronizer, which removes isolated one-cycle spikes at the cost of two
// extra cycles of delay on both edges.
// 'ready' goes high once the level output reflects real pin samples taken
// after reset rather than the reset contents of the pipeline.
module servo_in_sync
    import servo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ready
);

    logic s1;
    logic s2;
    logic s3;

`ifdef SERVO_DEC_GLITCH_EN
    localparam int READY_DEPTH = 5;
    logic s4;
    logic filt;
    logic filt_d;
`else
    localparam int READY_DEPTH = 2;
`endif

    logic [READY_DEPTH-1:0] fill;

    // Two-flop synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Shift in ones so the last stage marks when the level output is trustworthy
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
        end else begin
            fill <= {fill[READY_DEPTH-2:0], 1'b1};
        end
    end

    assign ready = fill[READY_DEPTH-1];

`ifdef SERVO_DEC_GLITCH_EN
    // Majority vote over three consecutive synchronized samples, then a history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            s4     <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            s4     <= s3;
            filt   <= (s2 & s3) | (s2 & s4) | (s3 & s4);
            filt_d <= filt;
        end
    end

    assign level = filt;
    assign rise  = filt & ~filt_d;
    assign fall  = ~filt & filt_d;
`else
    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
`endif

endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures the high time of a hobby-servo PWM input and
// converts it back into the 8-bit position used by the servo generator
// (position = (width >> FRAC_SHIFT) - 165, clamped to 0..255; the default
// shift of 8 gives 1 ms..2 ms at 50 MHz).
// Optional macro: SERVO_DEC_GLITCH_EN enables the input majority filter.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int MIN_W       = 40000,
    parameter int MAX_W       = 115000,
    parameter int TIMEOUT     = 1250000,
    parameter int LOCK_FRAMES = 2,
    parameter int FRAC_SHIFT  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] pos,
    output logic       pos_valid,
    output logic       locked,
    output logic       err_pulse
);

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_STOP = TO_W'(TIMEOUT);
    localparam logic [CTR_W-1:0] W_MIN   = CTR_W'(MIN_W);
    localparam logic [CTR_W-1:0] W_MAX   = CTR_W'(MAX_W);
    localparam logic [2:0]       LOCK_N  = 3'(LOCK_FRAMES);

    logic level;
    logic rise;
    logic fall;
    logic in_ready;

    dec_state_t state;
    dec_state_t state_nxt;

    logic [CTR_W-1:0] width_q;
    logic [CTR_W-1:0] width_scaled;
    logic [TO_W-1:0]  timer_q;
    logic [2:0]       good_q;

    logic timing;
    logic timeout_hit;
    logic eval_now;
    logic width_ok;
    logic accept;
    logic reject;

    servo_in_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .ready  (in_ready)
    );

    assign width_ok     = (width_q >= W_MIN) && (width_q <= W_MAX);
    assign width_scaled = width_q >> FRAC_SHIFT;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a timeout always wins over edges, so a late fall is discarded
    always_comb begin
        state_nxt = state;
        case (state)
            ARM: begin
                if (in_ready && !level) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (timeout_hit) begin
                    state_nxt = ARM;
                end else if (rise) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (timeout_hit) begin
                    state_nxt = ARM;
                end else if (fall) begin
                    state_nxt = LOW;
                end
            end
            default: begin
                state_nxt = ARM;
            end
        endcase
    end

    // FSM decode: when the timer is live, when it expires and how a fall is judged
    always_comb begin
        timing      = (state == LOW) || (state == HIGH);
        timeout_hit = timing && (timer_q == TO_LAST);
        eval_now    = (state == HIGH) && fall && !timeout_hit;
        accept      = eval_now && width_ok;
        reject      = eval_now && !width_ok;
    end

    // Width counter: starts at 1 on the rising edge and saturates while high
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q <= '0;
        end else if (rise) begin
            width_q <= CTR_W'(1);
        end else if ((state == HIGH) && (width_q != '1)) begin
            width_q <= width_q + 1'b1;
        end
    end

    // Rise-to-rise watchdog; parks at TIMEOUT in ARM and restarts when leaving ARM
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state == ARM) begin
            if (state_nxt == LOW) begin
                timer_q <= '0;
            end
        end else if (timeout_hit) begin
            timer_q <= TO_STOP;
        end else if ((state == LOW) && rise) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Result registers: position, strobes, good-frame count and lock flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pos       <= 8'd0;
            pos_valid <= 1'b0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
            good_q    <= 3'd0;
        end else begin
            pos_valid <= 1'b0;
            err_pulse <= 1'b0;
            if (timeout_hit) begin
                locked <= 1'b0;
                good_q <= 3'd0;
            end else if (accept) begin
                pos       <= width_to_pos(width_scaled);
                pos_valid <= 1'b1;
                if (good_q != LOCK_N) begin
                    good_q <= good_q + 3'd1;
                end
                if (good_q >= (LOCK_N - 3'd1)) begin
                    locked <= 1'b1;
                end
            end else if (reject) begin
                err_pulse <= 1'b1;
                good_q    <= 3'd0;
                locked    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: directed self-checking bench for servo_pwm_decoder.
// Runs the decoder with FRAC_SHIFT=0 and scaled-down limits so every frame is
// a few hundred cycles: position = width - 165, accepted widths 156..449,
// timeout 2000 cycles. Honours SERVO_DEC_GLITCH_EN for latency and spikes.
module tb_servo_pwm_decoder;

    localparam int MIN_W       = 156;
    localparam int MAX_W       = 449;
    localparam int TIMEOUT     = 2000;
    localparam int LOCK_FRAMES = 2;
    localparam int FRAC_SHIFT  = 0;
    localparam int LOW_N       = 600;

`ifdef SERVO_DEC_GLITCH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic [7:0] pos;
    logic       pos_valid;
    logic       locked;
    logic       err_pulse;

    int checks    = 0;
    int failures  = 0;
    int both_seen = 0;

    int   fr_valid;
    int   fr_err;
    int   fr_lat;
    logic fr_locked;

    always #5 clk = ~clk;

    servo_pwm_decoder #(
        .MIN_W       (MIN_W),
        .MAX_W       (MAX_W),
        .TIMEOUT     (TIMEOUT),
        .LOCK_FRAMES (LOCK_FRAMES),
        .FRAC_SHIFT  (FRAC_SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .pos       (pos),
        .pos_valid (pos_valid),
        .locked    (locked),
        .err_pulse (err_pulse)
    );

    // Drives one frame (high_n sampled-high cycles, then low_n low cycles with
    // optional single-cycle spikes) and records strobes; called at a negedge.
    task automatic run_frame(input int high_n, input int low_n, input int spike_a, input int spike_b);
        fr_valid = 0;
        fr_err   = 0;
        fr_lat   = -1;
        pwm_in   = 1'b1;
        for (int k = 1; k <= high_n; k++) begin
            @(negedge clk);
            if (pos_valid) fr_valid++;
            if (err_pulse) fr_err++;
            if (pos_valid && err_pulse) both_seen++;
        end
        for (int k = 1; k <= low_n; k++) begin
            pwm_in = (k == spike_a) || (k == spike_b);
            @(negedge clk);
            if (pos_valid) fr_valid++;
            if (err_pulse) fr_err++;
            if (pos_valid && err_pulse) both_seen++;
            if ((pos_valid || err_pulse) && (fr_lat < 0)) fr_lat = k;
        end
        pwm_in    = 1'b0;
        fr_locked = locked;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (pos !== 8'd0) begin failures++; $display("[TB] FAIL reset_pos: got %0d, expected 0", pos); end
        checks++; if (pos_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_pos_valid: got %b, expected 0", pos_valid); end
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked: got %b, expected 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_pulse: got %b, expected 0", err_pulse); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_nominal();
        run_frame(265, LOW_N, 0, 0);
        checks++; if (fr_valid != 1) begin failures++; $display("[TB] FAIL nom1_valid_count: got %0d, expected 1", fr_valid); end
        checks++; if (fr_err != 0) begin failures++; $display("[TB] FAIL nom1_err_count: got %0d, expected 0", fr_err); end
        checks++; if (fr_lat != LAT) begin failures++; $display("[TB] FAIL nom1_latency: got %0d, expected %0d", fr_lat, LAT); end
        checks++; if (pos !== 8'd100) begin failures++; $display("[TB] FAIL nom1_pos: got %0d, expected 100", pos); end
        checks++; if (fr_locked !== 1'b0) begin failures++; $display("[TB] FAIL nom1_locked: got %b, expected 0", fr_locked); end
        run_frame(265, LOW_N, 0, 0);
        checks++; if (pos !== 8'd100) begin failures++; $display("[TB] FAIL nom2_pos: got %0d, expected 100", pos); end
        checks++; if (fr_locked !== 1'b1) begin failures++; $display("[TB] FAIL nom2_locked: got %b, expected 1", fr_locked); end
    endtask

    task automatic test_mapping();
        int w[7]   = '{165, 420, 160, 425, 300, 156, 449};
        int exp[7] = '{0,   255, 0,   255, 135, 0,   255};
        for (int i = 0; i < 7; i++) begin
            run_frame(w[i], LOW_N, 0, 0);
            checks++; if (fr_valid != 1) begin failures++; $display("[TB] FAIL map_valid[%0d]: got %0d, expected 1", i, fr_valid); end
            checks++; if (fr_lat != LAT) begin failures++; $display("[TB] FAIL map_latency[%0d]: got %0d, expected %0d", i, fr_lat, LAT); end
            checks++; if (pos !== 8'(exp[i])) begin failures++; $display("[TB] FAIL map_pos[%0d]: got %0d, expected %0d", i, pos, exp[i]); end
            checks++; if (fr_locked !== 1'b1) begin failures++; $display("[TB] FAIL map_locked[%0d]: got %b, expected 1", i, fr_locked); end
        end
    endtask

    task automatic test_width_limits();
        int w[8]    = '{200, 100, 265, 265, 470, 155, 156, 450};
        int ev[8]   = '{1,   0,   1,   1,   0,   0,   1,   0};
        int ee[8]   = '{0,   1,   0,   0,   1,   1,   0,   1};
        int ep[8]   = '{35,  35,  100, 100, 100, 100, 0,   0};
        int el[8]   = '{1,   0,   0,   1,   0,   0,   0,   0};
        for (int i = 0; i < 8; i++) begin
            run_frame(w[i], LOW_N, 0, 0);
            checks++; if (fr_valid != ev[i]) begin failures++; $display("[TB] FAIL lim_valid[%0d]: got %0d, expected %0d", i, fr_valid, ev[i]); end
            checks++; if (fr_err != ee[i]) begin failures++; $display("[TB] FAIL lim_err[%0d]: got %0d, expected %0d", i, fr_err, ee[i]); end
            checks++; if (fr_lat != LAT) begin failures++; $display("[TB] FAIL lim_latency[%0d]: got %0d, expected %0d", i, fr_lat, LAT); end
            checks++; if (pos !== 8'(ep[i])) begin failures++; $display("[TB] FAIL lim_pos[%0d]: got %0d, expected %0d", i, pos, ep[i]); end
            checks++; if (fr_locked !== 1'(el[i])) begin failures++; $display("[TB] FAIL lim_locked[%0d]: got %b, expected %0d", i, fr_locked, el[i]); end
        end
    endtask

    task automatic test_timeout();
        int   drop;
        int   nv;
        int   ne;
        logic pre_lock;
        run_frame(265, LOW_N, 0, 0);
        run_frame(265, LOW_N, 0, 0);
        checks++; if (fr_locked !== 1'b1) begin failures++; $display("[TB] FAIL to_prelock: got %b, expected 1", fr_locked); end
        drop     = -1;
        nv       = 0;
        ne       = 0;
        pre_lock = 1'b0;
        pwm_in   = 1'b1;
        for (int idx = 1; idx <= TIMEOUT + 200; idx++) begin
            if (idx == 266) pwm_in = 1'b0;
            @(negedge clk);
            if (pos_valid) nv++;
            if (err_pulse) ne++;
            if (idx == LAT + TIMEOUT - 1) pre_lock = locked;
            if (!locked && (drop < 0)) drop = idx;
        end
        checks++; if (drop != LAT + TIMEOUT) begin failures++; $display("[TB] FAIL to_low_drop_cycle: got %0d, expected %0d", drop, LAT + TIMEOUT); end
        checks++; if (pre_lock !== 1'b1) begin failures++; $display("[TB] FAIL to_low_lock_before: got %b, expected 1", pre_lock); end
        checks++; if (nv != 1) begin failures++; $display("[TB] FAIL to_low_valid_count: got %0d, expected 1", nv); end
        checks++; if (ne != 0) begin failures++; $display("[TB] FAIL to_low_err_count: got %0d, expected 0", ne); end
        checks++; if (pos !== 8'd100) begin failures++; $display("[TB] FAIL to_low_pos: got %0d, expected 100", pos); end
    endtask

    task automatic test_stuck_high();
        int drop;
        int nv;
        int ne;
        run_frame(265, LOW_N, 0, 0);
        run_frame(265, LOW_N, 0, 0);
        checks++; if (fr_locked !== 1'b1) begin failures++; $display("[TB] FAIL sh_prelock: got %b, expected 1", fr_locked); end
        drop   = -1;
        nv     = 0;
        ne     = 0;
        pwm_in = 1'b1;
        for (int idx = 1; idx <= TIMEOUT + 200; idx++) begin
            @(negedge clk);
            if (pos_valid) nv++;
            if (err_pulse) ne++;
            if (!locked && (drop < 0)) drop = idx;
        end
        checks++; if (drop != LAT + TIMEOUT) begin failures++; $display("[TB] FAIL sh_drop_cycle: got %0d, expected %0d", drop, LAT + TIMEOUT); end
        checks++; if (nv != 0) begin failures++; $display("[TB] FAIL sh_valid_count: got %0d, expected 0", nv); end
        checks++; if (ne != 0) begin failures++; $display("[TB] FAIL sh_err_count: got %0d, expected 0", ne); end
        pwm_in = 1'b0;
        nv     = 0;
        for (int idx = 1; idx <= 50; idx++) begin
            @(negedge clk);
            if (pos_valid || err_pulse) nv++;
        end
        checks++; if (nv != 0) begin failures++; $display("[TB] FAIL sh_release_strobes: got %0d, expected 0", nv); end
    endtask

    task automatic test_reset_mid_pulse();
        int nv;
        int ne;
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (pos !== 8'd0) begin failures++; $display("[TB] FAIL mid_rst_pos: got %0d, expected 0", pos); end
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_locked: got %b, expected 0", locked); end
        nv = 0;
        ne = 0;
        for (int idx = 1; idx <= 150 + LOW_N; idx++) begin
            if (idx == 151) pwm_in = 1'b0;
            @(negedge clk);
            if (pos_valid) nv++;
            if (err_pulse) ne++;
        end
        checks++; if (nv != 0) begin failures++; $display("[TB] FAIL mid_rst_valid_count: got %0d, expected 0", nv); end
        checks++; if (ne != 0) begin failures++; $display("[TB] FAIL mid_rst_err_count: got %0d, expected 0", ne); end
        run_frame(265, LOW_N, 0, 0);
        checks++; if (fr_valid != 1) begin failures++; $display("[TB] FAIL mid_next_valid: got %0d, expected 1", fr_valid); end
        checks++; if (fr_lat != LAT) begin failures++; $display("[TB] FAIL mid_next_latency: got %0d, expected %0d", fr_lat, LAT); end
        checks++; if (pos !== 8'd100) begin failures++; $display("[TB] FAIL mid_next_pos: got %0d, expected 100", pos); end
    endtask

    task automatic test_glitch();
        int   exp_err;
        logic exp_lock;
`ifdef SERVO_DEC_GLITCH_EN
        exp_err  = 0;
        exp_lock = 1'b1;
`else
        exp_err  = 2;
        exp_lock = 1'b0;
`endif
        run_frame(300, LOW_N, 0, 0);
        run_frame(300, LOW_N, 0, 0);
        run_frame(265, LOW_N, 100, 300);
        checks++; if (fr_valid != 1) begin failures++; $display("[TB] FAIL gl_valid_count: got %0d, expected 1", fr_valid); end
        checks++; if (fr_err != exp_err) begin failures++; $display("[TB] FAIL gl_err_count: got %0d, expected %0d", fr_err, exp_err); end
        checks++; if (fr_lat != LAT) begin failures++; $display("[TB] FAIL gl_latency: got %0d, expected %0d", fr_lat, LAT); end
        checks++; if (pos !== 8'd100) begin failures++; $display("[TB] FAIL gl_pos: got %0d, expected 100", pos); end
        checks++; if (fr_locked !== exp_lock) begin failures++; $display("[TB] FAIL gl_locked: got %b, expected %b", fr_locked, exp_lock); end
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_mapping();
        test_width_limits();
        test_timeout();
        test_stuck_high();
        test_reset_mid_pulse();
        test_glitch();
        checks++; if (both_seen != 0) begin failures++; $display("[TB] FAIL strobe_overlap: got %0d, expected 0", both_seen); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
